// File: rtl/fec_arb_pkg.sv
//------------------------------------------------------------------------------
// fec_arb_pkg: shared constants, FSM state type and round-robin search. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fec_arb_pkg;

  localparam int c_wrf_dat_w = 16;
  localparam int c_wrf_adr_w = 2;
  localparam int c_wrf_sel_w = 2;
  localparam int c_max_ports = 4;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } t_arb_state;

  // First requester after `last`, walking last+1, last+2, ... modulo num_ports.
  // The search runs from farthest to nearest so the nearest hit is written last.
  // With no requester the result is `last`; callers qualify it with |req.
  function automatic logic [1:0] f_rr_next(input logic [3:0] req,
                                           input logic [1:0] last,
                                           input int         num_ports);
    logic [1:0] pick;
    logic [2:0] cand;
    pick = last;
    for (int k = c_max_ports; k >= 1; k--) begin
      if (k <= num_ports) begin
        cand = {1'b0, last} + 3'(k);
        if (cand >= 3'(num_ports)) cand = cand - 3'(num_ports);
        if (req[cand[1:0]]) pick = cand[1:0];
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fec_rr_picker.sv
//------------------------------------------------------------------------------
// fec_rr_picker: rotating-pointer request picker for fec_enc_arbiter. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fec_rr_picker
  import fec_arb_pkg::*;
#(
  parameter int g_num_ports = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [g_num_ports-1:0] req,
  input  logic                   take,
  output logic [1:0]             idx,
  output logic                   valid
);

  logic [1:0] last;
  logic [3:0] req_ext;

  always_comb begin
    req_ext                  = '0;
    req_ext[g_num_ports-1:0] = req;
  end

  assign idx   = f_rr_next(req_ext, last, g_num_ports);
  assign valid = |req;

  // Reset to the highest port so port 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 2'(g_num_ports - 1);
    end else if (take) begin
      last <= idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fec_enc_arbiter.sv
//------------------------------------------------------------------------------
// fec_enc_arbiter: packet-granular round-robin share of the FEC encoder sink. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fec_enc_arbiter
  import fec_arb_pkg::*;
#(
  parameter int g_num_ports = 2,
  parameter int g_cnt_width = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic [g_num_ports-1:0]             snk_cyc_i,
  input  logic [g_num_ports-1:0]             snk_stb_i,
  input  logic [g_num_ports-1:0]             snk_we_i,
  input  logic [c_wrf_sel_w*g_num_ports-1:0] snk_sel_i,
  input  logic [c_wrf_adr_w*g_num_ports-1:0] snk_adr_i,
  input  logic [c_wrf_dat_w*g_num_ports-1:0] snk_dat_i,
  output logic [g_num_ports-1:0]             snk_ack_o,
  output logic [g_num_ports-1:0]             snk_stall_o,
  output logic                               src_cyc_o,
  output logic                               src_stb_o,
  output logic                               src_we_o,
  output logic [c_wrf_sel_w-1:0]             src_sel_o,
  output logic [c_wrf_adr_w-1:0]             src_adr_o,
  output logic [c_wrf_dat_w-1:0]             src_dat_o,
  input  logic                               src_ack_i,
  input  logic                               src_stall_i,
  input  logic                               cnt_clr_i,
  output logic                               busy_o,
  output logic [g_cnt_width*g_num_ports-1:0] pkt_cnt_o
);

  t_arb_state state, state_nxt;
  logic [1:0] gnt;
  logic [1:0] pick_idx;
  logic       pick_valid;
  logic       take;
  logic       frame_done;

  fec_rr_picker #(
    .g_num_ports (g_num_ports)
  ) u_picker (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .req   (snk_cyc_i),
    .take  (take),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      if (take) gnt <= pick_idx;
    end
  end

  // In GRANT, src_cyc_o is the granted port's cyc, so its fall ends the frame.
  always_comb begin
    state_nxt  = state;
    take       = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          state_nxt = S_GRANT;
          take      = 1'b1;
        end
      end
      S_GRANT: begin
        if (!src_cyc_o) begin
          state_nxt  = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    src_cyc_o   = 1'b0;
    src_stb_o   = 1'b0;
    src_we_o    = 1'b0;
    src_sel_o   = '0;
    src_adr_o   = '0;
    src_dat_o   = '0;
    snk_ack_o   = '0;
    snk_stall_o = '1;
    if (state == S_GRANT) begin
      for (int p = 0; p < g_num_ports; p++) begin
        if (gnt == 2'(p)) begin
          src_cyc_o      = snk_cyc_i[p];
          src_stb_o      = snk_stb_i[p];
          src_we_o       = snk_we_i[p];
          src_sel_o      = snk_sel_i[p*c_wrf_sel_w +: c_wrf_sel_w];
          src_adr_o      = snk_adr_i[p*c_wrf_adr_w +: c_wrf_adr_w];
          src_dat_o      = snk_dat_i[p*c_wrf_dat_w +: c_wrf_dat_w];
          snk_ack_o[p]   = src_ack_i;
          snk_stall_o[p] = src_stall_i;
        end
      end
    end
  end

  assign busy_o = (state == S_GRANT);

  generate
    for (genvar p = 0; p < g_num_ports; p++) begin : g_cnt
      logic [g_cnt_width-1:0] cnt;

      // A clear wins over a frame ending in the same cycle.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          cnt <= '0;
        end else if (cnt_clr_i) begin
          cnt <= '0;
        end else if (frame_done && (gnt == 2'(p))) begin
          cnt <= cnt + 1'b1;
        end
      end

      assign pkt_cnt_o[p*g_cnt_width +: g_cnt_width] = cnt;
    end
  endgenerate

endmodule

`default_nettype wire
